// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data.
// Data side has priority, bounded by an anti-starvation counter.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_op,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] SMAX  = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]    OP_WORD = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    IBUSY,
    DBUSY,
    DONE
  } state_t;

  state_t        state_q;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] to_q, to_d;
  logic          d_win;

  logic        mem_req_q, mem_we_q;
  logic [2:0]  mem_op_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic        i_ack_q, i_err_q, d_ack_q, d_err_q;
  logic [31:0] i_rdata_q, d_rdata_q;

  // Arbitration decision and next values of the two counters
  always_comb begin
    d_win    = d_req & ((starve_q < SMAX) | ~i_req);
    starve_d = '0;
    if (d_win & i_req)
      starve_d = (starve_q == SMAX) ? SMAX : starve_q + SW'(1);
    to_d = to_q + TW'(1);
  end

  // Grant, memory handshake sequencing and one-cycle completion pulse
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      to_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_op_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (d_win) begin
            state_q     <= DBUSY;
            starve_q    <= starve_d;
            to_q        <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_op_q    <= d_op;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
          end else if (i_req) begin
            state_q     <= IBUSY;
            starve_q    <= '0;
            to_q        <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_op_q    <= OP_WORD;
            mem_addr_q  <= i_addr;
            mem_wdata_q <= '0;
          end
        end
        IBUSY, DBUSY: begin
          if (mem_ready || to_q == TLAST) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (state_q == DBUSY) begin
              d_ack_q   <= 1'b1;
              d_err_q   <= ~mem_ready;
              d_rdata_q <= (mem_ready & ~mem_we_q) ? mem_rdata : '0;
            end else begin
              i_ack_q   <= 1'b1;
              i_err_q   <= ~mem_ready;
              i_rdata_q <= mem_ready ? mem_rdata : '0;
            end
          end else begin
            to_q <= to_d;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          i_ack_q   <= 1'b0;
          i_err_q   <= 1'b0;
          i_rdata_q <= '0;
          d_ack_q   <= 1'b0;
          d_err_q   <= 1'b0;
          d_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_op    = mem_op_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule
